// File: rtl/dmem_load_unit.sv
// ---------------------------------------------------------------------------
// dmem_load_unit
//
// Multi-cycle load sequencer in front of the data-read register (DR) of a
// multi-cycle MIPS datapath. A one-cycle start request from the control unit
// launches a single data-memory read with a variable-latency ready handshake.
// The returned word is reduced to the byte/halfword/word chosen by load_type,
// sign- or zero-extended, and presented on load_data with a one-cycle DR
// write strobe (drr_in). A one-cycle done pulse reports completion, and a
// sticky err flag reports misalignment, an illegal load type or a memory
// timeout.
//
// Ports
//   clk        system clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   start      one-cycle load request, sampled only while idle
//   load_type  0=LW 1=LH 2=LHU 3=LB 4=LBU, 5..7 illegal
//   addr       effective byte address
//   mem_rdata  memory read word, valid with mem_ready
//   mem_ready  memory read-complete handshake
//   mem_req    read request, held until ready or timeout abort
//   mem_addr   word-aligned request address, captured at start
//   busy       high whenever the sequencer is not idle
//   load_data  extended load result (DR write data)
//   drr_in     one-cycle DR write enable
//   done       one-cycle completion pulse (success or error)
//   err        sticky error flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module dmem_load_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        busy,
  output logic [31:0] load_data,
  output logic        drr_in,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  // Last WAIT count value before the access is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXT  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  // Returns 1 when the request must be rejected without a memory access.
  function automatic logic bad_request(input logic [2:0] lt, input logic [1:0] off);
    logic bad;
    case (lt)
      LT_LW:          bad = (off != 2'b00);
      LT_LH, LT_LHU:  bad = off[0];
      LT_LB, LT_LBU:  bad = 1'b0;
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane select followed by sign/zero extension.
  function automatic logic [31:0] extend_load(input logic [2:0]  lt,
                                              input logic [1:0]  off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (lt)
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'h0000, h};
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'h000000, b};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e             state_q,     state_d;
  logic [2:0]         type_q,      type_d;
  logic [1:0]         off_q,       off_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [31:0]        rdata_q,     rdata_d;
  logic               mem_req_q,   mem_req_d;
  logic [31:0]        mem_addr_q,  mem_addr_d;
  logic               busy_q,      busy_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               drr_in_q,    drr_in_d;
  logic               done_q,      done_d;
  logic               err_q,       err_d;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    drr_in_d    = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          type_d     = load_type;
          off_d      = addr[1:0];
          mem_addr_d = {addr[31:2], 2'b00};
          if (bad_request(load_type, addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d     = {CNT_W{1'b0}};
        mem_req_d = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Ready on the final permitted cycle still completes the load.
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_EXT;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_FIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_EXT: begin
        load_data_d = extend_load(type_q, off_q, rdata_q);
        drr_in_d    = 1'b1;
        state_d     = S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any access immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      type_q      <= 3'd0;
      off_q       <= 2'd0;
      cnt_q       <= {CNT_W{1'b0}};
      rdata_q     <= 32'h0000_0000;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      busy_q      <= 1'b0;
      load_data_q <= 32'h0000_0000;
      drr_in_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      load_data_q <= load_data_d;
      drr_in_q    <= drr_in_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign load_data = load_data_q;
  assign drr_in    = drr_in_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_load_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_load_unit
//
// Self-checking bench for dmem_load_unit: a table of load requests with
// hand-derived results, a responding memory model that raises mem_ready
// after a programmed number of request cycles, a scoreboard queue of
// expected completions, and a hand-written asynchronous-reset sequence.
// ---------------------------------------------------------------------------
module tb_dmem_load_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  load_type;
  logic [31:0] addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        busy;
  logic [31:0] load_data;
  logic        drr_in;
  logic        done;
  logic        err;

  dmem_load_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_type (load_type),
    .addr      (addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .busy      (busy),
    .load_data (load_data),
    .drr_in    (drr_in),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // wt  : request cycles before the memory answers (0 = never)
  // req : expected number of cycles mem_req is high
  typedef struct {
    logic [2:0]  lt;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          wt;
    int          req;
    logic        err;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          req;
    int          drr_cyc;
    int          done_cyc;
    logic [31:0] maddr;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[18];
  logic [31:0] last_data;
  int          checks;
  int          errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one request, act as memory, and score the completion.
  task automatic run(input vec_t v, input bit poke);
    exp_t e;
    exp_t g;
    int   req_cnt;
    int   drr_cnt;
    int   drr_cyc;
    int   cyc;
    bit   seen;

    @(negedge clk);
    start     = 1'b1;
    load_type = v.lt;
    addr      = v.addr;
    e.err   = v.err;
    e.data  = v.err ? last_data : v.data;
    e.req   = v.req;
    e.maddr = {v.addr[31:2], 2'b00};
    if (!v.err) begin
      e.drr_cyc  = v.wt + 2;
      e.done_cyc = v.wt + 3;
      last_data  = v.data;
    end else if (v.req == 0) begin
      e.drr_cyc  = -1;
      e.done_cyc = 1;
    end else begin
      e.drr_cyc  = -1;
      e.done_cyc = TIMEOUT + 2;
    end
    sb.push_back(e);

    @(negedge clk);
    start = 1'b0;
    chk("err_at_accept", {31'd0, err}, {31'd0, (v.err && v.req == 0)});
    cyc = 0; seen = 1'b0; req_cnt = 0; drr_cnt = 0; drr_cyc = -1;
    while (!seen && cyc < 64) begin
      if (poke && (cyc == 0 || cyc == 2)) begin
        start     = 1'b1;
        load_type = 3'd0;
        addr      = 32'h0000_0F00;
      end else begin
        start = 1'b0;
      end
      if (mem_req) req_cnt++;
      mem_ready = mem_req && (v.wt != 0) && (req_cnt == v.wt);
      mem_rdata = mem_ready ? v.rdata : 32'hA5A5_5A5A;
      if (drr_in) begin
        drr_cnt++;
        drr_cyc = cyc;
        chk("data_at_strobe", load_data, e.data);
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready = 1'b0;
    start     = 1'b0;

    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none expected=done within 64 cycles");
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=done expected=pending entry");
    end else begin
      g = sb.pop_front();
      chk("err",       {31'd0, err},  {31'd0, g.err});
      chk("load_data", load_data,     g.data);
      chk("req_cycles", req_cnt,      g.req);
      chk("drr_count", drr_cnt,       (g.err ? 0 : 1));
      chk("drr_cycle", drr_cyc,       g.drr_cyc);
      chk("done_cycle", cyc,          g.done_cyc);
      chk("mem_addr",  mem_addr,      g.maddr);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("err_sticky",  {31'd0, err},   {31'd0, g.err});
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_data = 32'h0000_0000;
    start     = 1'b0;
    load_type = 3'd0;
    addr      = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    rst       = 1'b1;

    //            lt     addr          rdata          wt  req err   data
    vecs[0]  = '{3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 3,  3,  1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{3'd3, 32'h0000_0203, 32'h80FF_1234, 1,  1,  1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{3'd4, 32'h0000_0203, 32'h80FF_1234, 2,  2,  1'b0, 32'h0000_0080};
    vecs[3]  = '{3'd1, 32'h0000_0002, 32'h9ABC_0000, 1,  1,  1'b0, 32'hFFFF_9ABC};
    vecs[4]  = '{3'd2, 32'h0000_0000, 32'h0000_8001, 4,  4,  1'b0, 32'h0000_8001};
    vecs[5]  = '{3'd0, 32'h0000_0102, 32'h0,         0,  0,  1'b1, 32'h0};
    vecs[6]  = '{3'd1, 32'h0000_0101, 32'h0,         0,  0,  1'b1, 32'h0};
    vecs[7]  = '{3'd6, 32'h0000_0100, 32'h0,         0,  0,  1'b1, 32'h0};
    vecs[8]  = '{3'd0, 32'h0000_0200, 32'h0,         0,  16, 1'b1, 32'h0};
    vecs[9]  = '{3'd0, 32'h0000_0300, 32'h1234_5678, 16, 16, 1'b0, 32'h1234_5678};
    vecs[10] = '{3'd3, 32'h0000_0001, 32'h0000_7F00, 1,  1,  1'b0, 32'h0000_007F};
    vecs[11] = '{3'd1, 32'h0000_0000, 32'h0000_8000, 2,  2,  1'b0, 32'hFFFF_8000};
    vecs[12] = '{3'd4, 32'h0000_0002, 32'h00AB_0000, 1,  1,  1'b0, 32'h0000_00AB};
    vecs[13] = '{3'd5, 32'h0000_0000, 32'h0,         0,  0,  1'b1, 32'h0};
    vecs[14] = '{3'd2, 32'h0000_0003, 32'h0,         0,  0,  1'b1, 32'h0};
    vecs[15] = '{3'd2, 32'h0000_0002, 32'hF00D_0000, 1,  1,  1'b0, 32'h0000_F00D};
    vecs[16] = '{3'd7, 32'h0000_0004, 32'h0,         0,  0,  1'b1, 32'h0};
    vecs[17] = '{3'd3, 32'hFFFF_FFF0, 32'h0000_00C3, 5,  5,  1'b0, 32'hFFFF_FFC3};

    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_busy",      {31'd0, busy},    32'd0);
    chk("rst_done",      {31'd0, done},    32'd0);
    chk("rst_drr_in",    {31'd0, drr_in},  32'd0);
    chk("rst_err",       {31'd0, err},     32'd0);
    chk("rst_load_data", load_data,        32'h0);
    chk("rst_mem_addr",  mem_addr,         32'h0);
    rst = 1'b1;

    // Table-driven loads
    for (int i = 0; i < 18; i++) begin
      run(vecs[i], 1'b0);
    end

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    start     = 1'b1;
    load_type = 3'd0;
    addr      = 32'h0000_0400;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midwait_mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_mem_req",   {31'd0, mem_req}, 32'd0);
    chk("async_busy",      {31'd0, busy},    32'd0);
    chk("async_load_data", load_data,        32'h0);
    chk("async_mem_addr",  mem_addr,         32'h0);
    last_data = 32'h0000_0000;
    @(negedge clk);
    rst = 1'b1;

    // Stray ready while idle must not start anything
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_busy",    {31'd0, busy},   32'd0);
      chk("stray_drr_in",  {31'd0, drr_in}, 32'd0);
      chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
    end
    mem_ready = 1'b0;

    // Start pulses while busy are ignored, no queued second load
    run('{3'd3, 32'h0000_0502, 32'h0055_0000, 3, 3, 1'b0, 32'h0000_0055}, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_queue_busy", {31'd0, busy}, 32'd0);
      chk("no_queue_done", {31'd0, done}, 32'd0);
    end
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_load_unit.md
Name: dmem_load_unit

Overview:
- Multi-cycle load sequencer that sits directly upstream of the data-read register (DR) in the multi-cycle MIPS datapath.
- On a controller request it performs one data-memory read with a variable-latency ready handshake.
- It extracts and extends the byte, halfword or word selected by the load type.
- It presents the result on load_data with a one-cycle write strobe, so DR captures it on the following falling edge.

Parameters:
TIMEOUT, 16, maximum cycles spent in WAIT before abort (legal range 2..255)
CNT_W, 8, width of the wait counter; must hold TIMEOUT

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle load request from control unit; sampled only in IDLE
load_type  input  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; 5..7 illegal
addr  input  32  effective byte address (ALU output)
mem_rdata  input  32  data-memory read word, valid when mem_ready=1
mem_ready  input  1  memory read-complete handshake
mem_req  output  1  read request to data memory, held until ready or abort
mem_addr  output  32  word-aligned address (addr[31:2],2'b00), registered at start
busy  output  1  high in any state except IDLE
load_data  output  32  extended load result, feeds DR write-data input
drr_in  output  1  one-cycle DR write-enable strobe
done  output  1  one-cycle completion pulse to control unit (success or error)
err  output  1  sticky error flag: misalign, illegal type or timeout; cleared by next accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0; load_data=32'h0, mem_addr=32'h0.
  - Internal registers (type, offset, counter) cleared.
  - Reset in any state aborts the access immediately; mem_req drops asynchronously.
- States: IDLE, REQ, WAIT, EXT, FIN.
- IDLE:
  - When start=1, latch load_type, addr[1:0] and mem_addr, and clear err.
  - Alignment check:
    - LW requires addr[1:0]=00.
    - LH/LHU require addr[0]=0.
    - LB/LBU accept any address.
  - Misaligned address or illegal type: go to FIN with err=1 and no memory access.
  - Otherwise go to REQ.
- REQ: assert mem_req, clear counter, go to WAIT.
- WAIT:
  - mem_req stays 1; counter increments each cycle.
  - mem_ready=1: capture mem_rdata internally, deassert mem_req, go to EXT.
  - Counter reaches TIMEOUT-1 with mem_ready=0: drop mem_req, set err=1, go to FIN.
  - mem_ready on that same boundary cycle wins; no error.
  - mem_ready outside WAIT is ignored.
- EXT:
  - Select the lane by offset, little-endian: byte k = rdata[8k+7:8k], halfword h = rdata[16h+15:16h].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into load_data and pulse drr_in=1 for exactly this one cycle; DR latches at the falling edge inside the cycle.
  - Go to FIN.
- FIN:
  - done=1 for one cycle, then go to IDLE.
  - On error paths load_data holds its previous value and drr_in stays 0.
- start outside IDLE is ignored, with no queueing.
- Latency:
  - Successful load: start accepted at edge 0, mem_ready seen at edge N (N≥2), drr_in high during cycle N+1, done high during cycle N+2.
  - Zero-wait memory (ready in first WAIT cycle): drr_in is 3 cycles after start.
- load_data is stable from EXT until the next successful EXT.

Test Plan:
1. Reset, then LW addr=0x100, mem_ready after 3 WAIT cycles with rdata=0xDEADBEEF → mem_addr=0x100, mem_req high 3 cycles, drr_in 1 cycle with load_data=0xDEADBEEF, done next cycle, err=0.
2. LB addr=0x203, rdata=0x80FF1234; then LBU same address → load_data=0xFFFFFF80, then 0x00000080.
3. LH addr=0x002, rdata=0x9ABC0000; then LHU addr=0x000, rdata=0x00008001 → 0xFFFF9ABC, then 0x00008001.
4. LW addr=0x102; then LH addr=0x101; then load_type=6 → each: no mem_req, done 1 cycle after start, err=1, drr_in=0, load_data unchanged.
5. LW with mem_ready never asserted, TIMEOUT=16 → mem_req high exactly 16 cycles, then err=1, done pulse, no drr_in; next valid start clears err.
6. rst=0 mid-WAIT → mem_req/busy drop without a clock edge; after release, stray mem_ready and start pulses issued while busy are ignored.
